octree_locator: RTL and testbench

- Upstream neighbour of the ray stepper.
- Given a ray position q, walks the sparse voxel octree held in node memory from the root down to the leaf containing q.
- Returns that leaf's axis-aligned bounds l/u (fed directly to the stepper's l/u inputs) plus the leaf's occupancy and material.
- Traversal is iterative, one node read per level, over a request/grant/valid memory port.

---
 rtl/octree_locator.sv | 191 +++++++++++++++++++
 tb/tb_octree_locator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/octree_locator.sv
// Sparse voxel octree point locator: walks node memory from the root to the leaf
// holding q and reports that leaf's bounds, occupancy and material.
module octree_locator #(
  parameter int WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ROOT_ADDR = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             q [3],
  output logic                         rdReq,
  output logic [ADDR_WIDTH-1:0]        rdAddr,
  input  logic                         rdGnt,
  input  logic                         rdValid,
  input  logic [DATA_WIDTH-1:0]        rdData,
  output logic                         done,
  output logic [WIDTH-1:0]             l [3],
  output logic [WIDTH-1:0]             u [3],
  output logic                         solid,
  output logic [7:0]                   material,
  output logic [$clog2(WIDTH+1)-1:0]   depth,
  output logic                         malformed
);

  localparam int DEPTH_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_REQ,
    S_WAIT
  } state_t;

  state_t                r_state;
  logic                  r_rdreq;
  logic [ADDR_WIDTH-1:0] r_rdaddr;
  logic                  r_done;
  logic [WIDTH-1:0]      r_q [3];
  logic [WIDTH-1:0]      r_l [3];
  logic [WIDTH-1:0]      r_u [3];
  logic                  r_solid;
  logic [7:0]            r_material;
  logic [DEPTH_W-1:0]    r_depth;
  logic [DEPTH_W-1:0]    r_lvl;
  logic                  r_malformed;
  logic                  r_pend;
  logic                  r_stale;

  logic [WIDTH-1:0]      w_mask;
  logic [WIDTH-1:0]      w_qsh [3];
  logic [WIDTH-1:0]      w_lo [3];
  logic [WIDTH-1:0]      w_hi [3];
  logic [2:0]            w_idx;
  logic [ADDR_WIDTH-1:0] w_child_addr;
  logic                  w_leaf;
  logic                  w_at_unit;
  logic                  w_unused;

  // Cell at level r_lvl spans 2^(WIDTH-r_lvl) per axis; the mask covers its offset bits.
  assign w_mask = {WIDTH{1'b1}} >> r_lvl;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
      // Shifting left by the level puts the bit selecting this level's child at the MSB.
      assign w_qsh[gi]   = r_q[gi] << r_lvl;
      assign w_idx[2-gi] = w_qsh[gi][WIDTH-1];
      assign w_lo[gi]    = r_q[gi] & ~w_mask;
      assign w_hi[gi]    = w_lo[gi] | w_mask;
      assign l[gi]       = r_l[gi];
      assign u[gi]       = r_u[gi];
    end
  endgenerate

  assign w_child_addr = rdData[ADDR_WIDTH-1:0] + {{(ADDR_WIDTH-3){1'b0}}, w_idx};
  assign w_leaf       = rdData[DATA_WIDTH-1];
  assign w_at_unit    = (r_lvl == DEPTH_W'(WIDTH));
  assign w_unused     = ^rdData;

  assign rdReq     = r_rdreq;
  assign rdAddr    = r_rdaddr;
  assign done      = r_done;
  assign solid     = r_solid;
  assign material  = r_material;
  assign depth     = r_depth;
  assign malformed = r_malformed;

  // A read granted but not yet returned when reset hits becomes stale: its
  // response must be swallowed rather than decoded by the next lookup.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend  <= 1'b0;
      r_stale <= (r_stale | r_pend | (r_rdreq & rdGnt)) & ~rdValid;
    end else begin
      if (r_rdreq && rdGnt) begin
        r_pend <= 1'b1;
      end else if (rdValid && !r_stale) begin
        r_pend <= 1'b0;
      end
      if (rdValid) begin
        r_stale <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rdreq     <= 1'b0;
      r_rdaddr    <= '0;
      r_done      <= 1'b1;
      r_lvl       <= '0;
      r_depth     <= '0;
      r_solid     <= 1'b0;
      r_material  <= '0;
      r_malformed <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_q[i] <= '0;
        r_l[i] <= '0;
        r_u[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < 3; i++) begin
              r_q[i] <= q[i];
            end
            r_rdaddr    <= ROOT_ADDR;
            r_lvl       <= '0;
            r_malformed <= 1'b0;
            r_done      <= 1'b0;
            if (r_stale && !rdValid) begin
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_REQ;
              r_rdreq <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (rdValid) begin
            r_state <= S_REQ;
            r_rdreq <= 1'b1;
          end
        end
        S_REQ: begin
          if (rdGnt) begin
            r_rdreq <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rdValid) begin
            if (w_leaf) begin
              for (int i = 0; i < 3; i++) begin
                r_l[i] <= w_lo[i];
                r_u[i] <= w_hi[i];
              end
              r_solid    <= rdData[DATA_WIDTH-2];
              r_material <= rdData[7:0];
              r_depth    <= r_lvl;
              r_done     <= 1'b1;
              r_state    <= S_IDLE;
            end else if (w_at_unit) begin
              // Internal node below unit-cell size: the tree is corrupt.
              for (int i = 0; i < 3; i++) begin
                r_l[i] <= r_q[i];
                r_u[i] <= r_q[i];
              end
              r_malformed <= 1'b1;
              r_solid     <= 1'b1;
              r_material  <= '0;
              r_depth     <= DEPTH_W'(WIDTH);
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_rdaddr <= w_child_addr;
              r_lvl    <= r_lvl + DEPTH_W'(1);
              r_rdreq  <= 1'b1;
              r_state  <= S_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_octree_locator.sv
// Bench for octree_locator: directed scenarios plus random trees, checked against
// a direct tree-walk reference model and a configurable-latency memory model.
module tb_octree_locator;
  localparam int W  = 16;
  localparam int AW = 20;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  q [3];
  logic          rdReq;
  logic [AW-1:0] rdAddr;
  logic          rdGnt;
  logic          rdValid;
  logic [DW-1:0] rdData;
  logic          done;
  logic [W-1:0]  l [3];
  logic [W-1:0]  u [3];
  logic          solid;
  logic [7:0]    material;
  logic [4:0]    depth;
  logic          malformed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  octree_locator dut (
    .clock(clock), .reset(reset), .start(start), .q(q),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdGnt(rdGnt), .rdValid(rdValid), .rdData(rdData),
    .done(done), .l(l), .u(u), .solid(solid), .material(material),
    .depth(depth), .malformed(malformed)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Node memory: absent words read as leaves so a bad address still terminates.
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] rd(input logic [19:0] a);
    if (mem.exists(32'(a))) return mem[32'(a)];
    return 32'h8000_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Memory responder: grant after gd stall cycles, data vd cycles after the one following grant.
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;
  resp_t       resp_q[$];
  int          gd = 0;
  int          vd = 0;
  bit          holding = 0;
  logic [19:0] held_addr;
  int          wcnt = 0;

  initial begin
    rdGnt = 1'b0;
    rdValid = 1'b0;
    rdData = '0;
    forever begin
      @(negedge clock);
      rdGnt = 1'b0;
      rdValid = 1'b0;
      rdData = $urandom;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        rdValid = 1'b1;
        rdData = resp_q[0].data;
        void'(resp_q.pop_front());
      end
      if (rdReq === 1'b1) begin
        if (!holding) begin
          holding = 1;
          held_addr = rdAddr;
          wcnt = 0;
        end else begin
          chk("rdaddr_stable", 32'(rdAddr), 32'(held_addr));
        end
        if (wcnt == gd) begin
          resp_t r;
          rdGnt = 1'b1;
          r.due = cyc + 1 + vd;
          r.data = rd(rdAddr);
          resp_q.push_back(r);
          holding = 0;
        end else begin
          wcnt++;
        end
      end else begin
        holding = 0;
      end
    end
  end

  // Reference: walk the tree using the node-format and bound-mask rules directly.
  logic [15:0] exp_l [3];
  logic [15:0] exp_u [3];
  logic        exp_solid;
  logic [7:0]  exp_mat;
  int          exp_depth;
  logic        exp_mal;
  int          exp_reads;

  task automatic ref_lookup(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    logic [15:0] qa [3];
    logic [19:0] a;
    logic [31:0] w;
    logic [15:0] mask;
    logic [2:0]  idx;
    qa[0] = a0; qa[1] = a1; qa[2] = a2;
    a = 20'h0;
    for (int d = 0; d <= 16; d++) begin
      w = rd(a);
      exp_reads = d + 1;
      if (w[31]) begin
        mask = 16'((32'd1 << (16 - d)) - 32'd1);
        for (int i = 0; i < 3; i++) begin
          exp_l[i] = qa[i] & ~mask;
          exp_u[i] = exp_l[i] | mask;
        end
        exp_solid = w[30];
        exp_mat = w[7:0];
        exp_depth = d;
        exp_mal = 1'b0;
        return;
      end
      if (d == 16) begin
        for (int i = 0; i < 3; i++) begin
          exp_l[i] = qa[i];
          exp_u[i] = qa[i];
        end
        exp_solid = 1'b1;
        exp_mat = 8'h00;
        exp_depth = 16;
        exp_mal = 1'b1;
        return;
      end
      idx = {qa[0][15-d], qa[1][15-d], qa[2][15-d]};
      a = 20'(w[19:0] + 20'(idx));
    end
  endtask

  // Issues one lookup at the current negedge; extra = cycles spent draining a stale read.
  task automatic lookup(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                        input int g, input int v, input int extra, input bit pulse);
    int lat;
    int exp_lat;
    gd = g;
    vd = v;
    ref_lookup(a0, a1, a2);
    exp_lat = 1 + extra + exp_reads * (g + v + 2);
    q[0] = a0; q[1] = a1; q[2] = a2;
    start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k <= extra) chk("drain_no_req", 32'(rdReq), 32'd0);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (pulse && k == 3) begin
        q[0] = ~a0; q[1] = a1 ^ 16'h5a5a; q[2] = ~a2;
        start = 1'b1;
      end
      if (pulse && k == 4) start = 1'b0;
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("l%0d", i), 32'(l[i]), 32'(exp_l[i]));
      chk($sformatf("u%0d", i), 32'(u[i]), 32'(exp_u[i]));
    end
    chk("solid", 32'(solid), 32'(exp_solid));
    chk("material", 32'(material), 32'(exp_mat));
    chk("depth", 32'(depth), 32'(exp_depth));
    chk("malformed", 32'(malformed), 32'(exp_mal));
    $display("lookup q=(%h,%h,%h) gnt_wait=%0d val_wait=%0d depth=%0d malformed=%0b latency=%0d",
             a0, a1, a2, g, v, depth, malformed, lat);
  endtask

  task automatic chk_reset_state();
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_rdreq", 32'(rdReq), 32'd0);
    chk("rst_rdaddr", 32'(rdAddr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_l%0d", i), 32'(l[i]), 32'd0);
      chk($sformatf("rst_u%0d", i), 32'(u[i]), 32'd0);
    end
    chk("rst_solid", 32'(solid), 32'd0);
    chk("rst_material", 32'(material), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_malformed", 32'(malformed), 32'd0);
  endtask

  task automatic build_random_tree(input int maxd);
    int          qa [$];
    int          qd [$];
    int          next_free;
    int          a;
    int          d;
    logic [31:0] w;
    mem.delete();
    next_free = 8;
    qa.push_back(0);
    qd.push_back(0);
    while (qa.size() > 0) begin
      a = qa.pop_front();
      d = qd.pop_front();
      w = $urandom;
      if (d < maxd && $urandom_range(0, 99) < 55 && next_free < 4000) begin
        w[31] = 1'b0;
        w[19:0] = 20'(next_free);
        for (int i = 0; i < 8; i++) begin
          qa.push_back(next_free + i);
          qd.push_back(d + 1);
        end
        next_free += 8;
      end else begin
        w[31] = 1'b1;
      end
      mem[32'(a)] = w;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    q[0] = '0; q[1] = '0; q[2] = '0;
    repeat (3) @(negedge clock);
    chk_reset_state();
    reset = 1'b0;

    // Root is a leaf.
    mem.delete();
    mem[0] = 32'hC000_002A;
    lookup(16'd5, 16'd6, 16'd7, 0, 0, 0, 0);

    // One level down: child 5 of base 0x10.
    mem.delete();
    mem[0] = 32'h0000_0010;
    for (int i = 0; i < 8; i++) mem[32'(16 + i)] = 32'h8000_0000 | 32'(i);
    lookup(16'h8000, 16'h0000, 16'h8000, 0, 0, 0, 0);

    // Same path with a stalled memory and a start pulse that must be ignored.
    lookup(16'h8000, 16'h0000, 16'h8000, 3, 3, 0, 1);

    // Child base wraps past the top of the address space.
    mem.delete();
    mem[0] = 32'h000F_FFFD;
    mem[2] = 32'hC000_0077;
    lookup(16'h8000, 16'h1234, 16'hC000, 0, 0, 0, 0);

    // Self-referencing internal nodes: runs past unit-cell depth.
    mem.delete();
    mem[0] = 32'h0000_0100;
    for (int i = 0; i < 8; i++) mem[32'(256 + i)] = 32'h0000_0100;
    lookup(16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 0, 0, 0, 0);

    // Reset one cycle after the root grant; the stale leaf word must be discarded.
    mem.delete();
    mem[0] = 32'hC000_00EE;
    for (int i = 0; i < 8; i++) mem[32'(16 + i)] = 32'h8000_0040 | 32'(i);
    gd = 0;
    vd = 3;
    q[0] = 16'h1111; q[1] = 16'h2222; q[2] = 16'h3333;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    mem[0] = 32'h0000_0010;
    @(negedge clock);
    reset = 1'b0;
    chk_reset_state();
    lookup(16'h0000, 16'hC000, 16'h4000, 0, 3, 2, 0);

    // Random trees, positions and memory timing.
    for (int t = 0; t < 24; t++) begin
      build_random_tree($urandom_range(1, 5));
      lookup(16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), 0, ($urandom_range(0, 3) == 0));
    end

    repeat (8) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
